pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Holds its own shadow copies of EX, MEM and WB destination/source tags, so the datapath only presents the decoded ID-stage instruction.
- Produces stall, flush, bubble and forwarding selects, freezes the pipeline while data memory is not ready, and counts stall cycles.
- Adds a no-forwarding mode and a wider register-address option.

---
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding control for a 5-stage pipeline, tracking EX/MEM/WB tags in shadow registers.
// Control outputs are combinational from ID inputs and shadow state; shadow advances next cycle and holds while memory stalls.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              br_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              cnt_clr,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_en,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } shadow_t;

  shadow_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freeze, hazard, rs_hit, rt_hit;
  logic             wb_unused;

  function automatic logic writes(input shadow_t e, input logic [REG_AW-1:0] r);
    return e.valid && e.regwrite && (e.rd == r) && (r != '0);
  endfunction

  // MEM is checked first so the youngest producer wins.
  function automatic logic [1:0] fwd_sel(input shadow_t m, input shadow_t w,
                                         input logic [REG_AW-1:0] r);
    if (FWD_EN == 0) return 2'b00;
    if (writes(m, r)) return 2'b10;
    if (writes(w, r)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    freeze = mem_req & ~mem_ready;
    if (FWD_EN != 0) begin
      rs_hit = ex_q.memread & writes(ex_q, id_rs);
      rt_hit = ex_q.memread & writes(ex_q, id_rt);
    end else begin
      // WB is excluded: the register file writes before ID reads it.
      rs_hit = writes(ex_q, id_rs) | writes(mem_q, id_rs);
      rt_hit = writes(ex_q, id_rt) | writes(mem_q, id_rt);
    end
    hazard = id_valid & ((id_use_rs & rs_hit) | (id_use_rt & rt_hit));
  end

  assign pipe_en     = ~freeze;
  assign pc_write    = ~freeze & ~hazard;
  assign ifid_write  = ~freeze & ~hazard;
  assign idex_bubble = hazard & ~freeze;
  assign ifid_flush  = br_taken & ~hazard & ~freeze;
  assign fwd_a       = fwd_sel(mem_q, wb_q, ex_q.rs);
  assign fwd_b       = fwd_sel(mem_q, wb_q, ex_q.rt);
  assign stall_cnt   = cnt_q;

  // WB only ever serves as a forwarding source; its source tags are kept for completeness.
  assign wb_unused = wb_q.memread ^ (^wb_q.rs) ^ (^wb_q.rt);

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (hazard) begin
        ex_d = '0;
      end else begin
        ex_d.valid    = id_valid;
        ex_d.rd       = id_rd;
        ex_d.regwrite = id_regwrite;
        ex_d.memread  = id_memread;
        ex_d.rs       = id_rs;
        ex_d.rt       = id_rt;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (!pc_write && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (no forwarding, forwarding, 4-bit counter) on shared stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic       br_taken, mem_req, mem_ready, cnt_clr;
  logic [4:0] id_rs, id_rt, id_rd;

  logic        pcw_f0, ifw_f0, flush_f0, bub_f0, pen_f0;
  logic        pcw_f1, ifw_f1, flush_f1, bub_f1, pen_f1;
  logic        pcw_c4, ifw_c4, flush_c4, bub_c4, pen_c4;
  logic [1:0]  fa_f0, fb_f0, fa_f1, fb_f1, fa_c4, fb_c4;
  logic [15:0] cnt_f0, cnt_f1;
  logic [3:0]  cnt_c4;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(16)) u_f0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .pc_write(pcw_f0), .ifid_write(ifw_f0), .ifid_flush(flush_f0),
    .idex_bubble(bub_f0), .pipe_en(pen_f0), .fwd_a(fa_f0), .fwd_b(fb_f0),
    .stall_cnt(cnt_f0));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .CNT_W(16)) u_f1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .pc_write(pcw_f1), .ifid_write(ifw_f1), .ifid_flush(flush_f1),
    .idex_bubble(bub_f1), .pipe_en(pen_f1), .fwd_a(fa_f1), .fwd_b(fb_f1),
    .stall_cnt(cnt_f1));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .pc_write(pcw_c4), .ifid_write(ifw_c4), .ifid_flush(flush_c4),
    .idex_bubble(bub_c4), .pipe_en(pen_c4), .fwd_a(fa_c4), .fwd_b(fb_c4),
    .stall_cnt(cnt_c4));

  // Reference model: per pipeline flavour (0 = no forwarding, 1 = forwarding) a list of
  // in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  int     mv[2][3], mrd[2][3], mrw[2][3], mmr[2][3], mrs[2][3], mrt[2][3];
  longint mcnt[3];
  longint cmax[3] = '{65535, 65535, 15};

  function automatic bit m_writes(int md, int st, int r);
    return mv[md][st] != 0 && mrw[md][st] != 0 && mrd[md][st] == r && r != 0;
  endfunction

  function automatic bit m_hazard(int md);
    int reach;
    bit h;
    reach = (md == 1) ? 1 : 2;
    h = 0;
    if (!id_valid) return 0;
    for (int s = 0; s < reach; s++) begin
      if (md == 1 && mmr[md][s] == 0) continue;
      if (id_use_rs && m_writes(md, s, int'(id_rs))) h = 1;
      if (id_use_rt && m_writes(md, s, int'(id_rt))) h = 1;
    end
    return h;
  endfunction

  function automatic logic [1:0] m_fwd(int md, int r);
    if (md == 0) return 2'b00;
    if (m_writes(md, 1, r)) return 2'b10;
    if (m_writes(md, 2, r)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_tick();
    bit frz, pcw;
    bit hz[2];
    frz   = mem_req && !mem_ready;
    hz[0] = m_hazard(0);
    hz[1] = m_hazard(1);
    for (int k = 0; k < 3; k++) begin
      pcw = !frz && !hz[(k == 0) ? 0 : 1];
      if (rst || cnt_clr) mcnt[k] = 0;
      else if (!pcw && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
    end
    for (int md = 0; md < 2; md++) begin
      if (rst) begin
        for (int s = 0; s < 3; s++) mv[md][s] = 0;
      end else if (!frz) begin
        for (int s = 2; s >= 1; s--) begin
          mv[md][s]  = mv[md][s-1];  mrd[md][s] = mrd[md][s-1];
          mrw[md][s] = mrw[md][s-1]; mmr[md][s] = mmr[md][s-1];
          mrs[md][s] = mrs[md][s-1]; mrt[md][s] = mrt[md][s-1];
        end
        if (hz[md]) begin
          mv[md][0] = 0; mrd[md][0] = 0; mrw[md][0] = 0;
          mmr[md][0] = 0; mrs[md][0] = 0; mrt[md][0] = 0;
        end else begin
          mv[md][0]  = int'(id_valid);    mrd[md][0] = int'(id_rd);
          mrw[md][0] = int'(id_regwrite); mmr[md][0] = int'(id_memread);
          mrs[md][0] = int'(id_rs);       mrt[md][0] = int'(id_rt);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_use_rs = 0; id_use_rt = 0;
    id_regwrite = 0; id_memread = 0; br_taken = 0; mem_req = 0; mem_ready = 1;
    cnt_clr = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic urs, input logic urt, input logic rw, input logic mr);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_use_rs = urs; id_use_rt = urt; id_regwrite = rw; id_memread = mr;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    settle();
    checks++;
    if ({pcw_f1, ifw_f1, pen_f1, flush_f1, bub_f1, fa_f1, fb_f1} !== 9'b111_0_0_00_00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b need 111000000",
               {pcw_f1, ifw_f1, pen_f1, flush_f1, bub_f1, fa_f1, fb_f1});
    end
    checks++;
    if (cnt_f0 !== 16'd0 || cnt_f1 !== 16'd0 || cnt_c4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d need 0/0/0", cnt_f0, cnt_f1, cnt_c4);
    end
  endtask

  task automatic test_load_use();
    int stalls, bubbles;
    stalls = 0; bubbles = 0;
    do_reset();
    set_id(5'd0, 5'd0, 5'd8, 1, 0, 1, 1);
    tick();
    set_id(5'd8, 5'd8, 5'd9, 1, 1, 1, 0);
    for (int c = 0; c < 2; c++) begin
      settle();
      if (!pcw_f1) stalls++;
      if (bub_f1) bubbles++;
      tick();
    end
    idle();
    settle();
    checks++;
    if (stalls != 1 || bubbles != 1) begin
      errors++;
      $display("FAIL load_use_stall: stalls=%0d bubbles=%0d need 1/1", stalls, bubbles);
    end
    checks++;
    if (fa_f1 !== 2'b01 || fb_f1 !== 2'b01) begin
      errors++;
      $display("FAIL load_use_fwd: got %b/%b need 01/01", fa_f1, fb_f1);
    end
    checks++;
    if (cnt_f1 !== 16'd1) begin
      errors++;
      $display("FAIL load_use_cnt: got %0d need 1", cnt_f1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(5'd1, 5'd2, 5'd3, 1, 1, 1, 0);
    tick();
    set_id(5'd3, 5'd3, 5'd4, 1, 1, 1, 0);
    settle();
    checks++;
    if (pcw_f1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_nostall: pc_write=%b need 1", pcw_f1);
    end
    tick();
    idle();
    settle();
    checks++;
    if (fa_f1 !== 2'b10 || fb_f1 !== 2'b10) begin
      errors++;
      $display("FAIL b2b_fwd: got %b/%b need 10/10", fa_f1, fb_f1);
    end
    checks++;
    if (fa_f0 !== 2'b00 || fb_f0 !== 2'b00) begin
      errors++;
      $display("FAIL b2b_nofwd_mode: got %b/%b need 00/00", fa_f0, fb_f0);
    end
    tick();
    set_id(5'd1, 5'd2, 5'd0, 1, 1, 1, 0);
    tick();
    set_id(5'd0, 5'd0, 5'd4, 1, 1, 1, 0);
    tick();
    idle();
    settle();
    checks++;
    if (fa_f1 !== 2'b00 || fb_f1 !== 2'b00) begin
      errors++;
      $display("FAIL b2b_zero_reg: got %b/%b need 00/00", fa_f1, fb_f1);
    end
  endtask

  task automatic test_no_fwd();
    int stalls, fwd_bad;
    stalls = 0; fwd_bad = 0;
    do_reset();
    set_id(5'd1, 5'd2, 5'd5, 1, 1, 1, 0);
    tick();
    set_id(5'd5, 5'd0, 5'd6, 1, 1, 1, 0);
    for (int c = 0; c < 3; c++) begin
      settle();
      if (!pcw_f0) stalls++;
      if (fa_f0 !== 2'b00 || fb_f0 !== 2'b00) fwd_bad++;
      tick();
    end
    idle();
    for (int c = 0; c < 2; c++) begin
      settle();
      if (fa_f0 !== 2'b00 || fb_f0 !== 2'b00) fwd_bad++;
      tick();
    end
    checks++;
    if (stalls != 2 || fwd_bad != 0) begin
      errors++;
      $display("FAIL no_fwd_stall: stalls=%0d fwd_nonzero=%0d need 2/0", stalls, fwd_bad);
    end
    checks++;
    if (cnt_f0 !== 16'd2 || cnt_f1 !== 16'd0) begin
      errors++;
      $display("FAIL no_fwd_cnt: got %0d (fwd inst %0d) need 2 (0)", cnt_f0, cnt_f1);
    end
  endtask

  task automatic test_freeze();
    int bad;
    bad = 0;
    do_reset();
    set_id(5'd1, 5'd2, 5'd7, 1, 1, 1, 0);
    tick();
    set_id(5'd7, 5'd7, 5'd8, 1, 1, 1, 0);
    mem_req = 1; mem_ready = 0; br_taken = 1;
    for (int c = 0; c < 3; c++) begin
      settle();
      if (pen_f1 !== 1'b0 || pcw_f1 !== 1'b0 || ifw_f1 !== 1'b0 ||
          flush_f1 !== 1'b0 || bub_f1 !== 1'b0) bad++;
      tick();
    end
    mem_req = 0; mem_ready = 1; br_taken = 0;
    settle();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL freeze_ctrl: bad cycles=%0d need 0", bad);
    end
    checks++;
    if (cnt_f1 !== 16'd3 || pcw_f1 !== 1'b1) begin
      errors++;
      $display("FAIL freeze_cnt: cnt=%0d pc_write=%b need 3/1", cnt_f1, pcw_f1);
    end
    tick();
    idle();
    settle();
    checks++;
    if (fa_f1 !== 2'b10 || fb_f1 !== 2'b10) begin
      errors++;
      $display("FAIL freeze_shadow_hold: got %b/%b need 10/10", fa_f1, fb_f1);
    end
  endtask

  task automatic test_branch_hazard();
    do_reset();
    set_id(5'd0, 5'd0, 5'd8, 1, 0, 1, 1);
    tick();
    set_id(5'd8, 5'd0, 5'd9, 1, 0, 1, 0);
    br_taken = 1;
    settle();
    checks++;
    if (flush_f1 !== 1'b0 || pcw_f1 !== 1'b0 || bub_f1 !== 1'b1) begin
      errors++;
      $display("FAIL branch_hazard: flush=%b pcw=%b bub=%b need 0/0/1", flush_f1, pcw_f1, bub_f1);
    end
    tick();
    settle();
    checks++;
    if (flush_f1 !== 1'b1 || pcw_f1 !== 1'b1) begin
      errors++;
      $display("FAIL branch_retry: flush=%b pcw=%b need 1/1", flush_f1, pcw_f1);
    end
    idle();
  endtask

  task automatic test_counter();
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 20; c++) tick();
    mem_req = 0; mem_ready = 1;
    settle();
    checks++;
    if (cnt_c4 !== 4'd15 || cnt_f1 !== 16'd20) begin
      errors++;
      $display("FAIL cnt_saturate: got %0d (wide %0d) need 15 (20)", cnt_c4, cnt_f1);
    end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    settle();
    checks++;
    if (cnt_c4 !== 4'd0 || cnt_f1 !== 16'd0) begin
      errors++;
      $display("FAIL cnt_clear: got %0d/%0d need 0/0", cnt_c4, cnt_f1);
    end
    set_id(5'd0, 5'd0, 5'd8, 1, 0, 1, 1);
    tick();
    set_id(5'd8, 5'd8, 5'd9, 1, 1, 1, 0);
    settle();
    checks++;
    if (pcw_f1 !== 1'b0) begin
      errors++;
      $display("FAIL cnt_pre_rst_stall: pc_write=%b need 0", pcw_f1);
    end
    rst = 1;
    tick();
    rst = 0;
    settle();
    checks++;
    if ({pcw_f1, ifw_f1, pen_f1, flush_f1, bub_f1, fa_f1, fb_f1} !== 9'b111_0_0_00_00 ||
        cnt_f1 !== 16'd0 || cnt_c4 !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_stall: ctrl=%b cnt=%0d/%0d need 111000000 0/0",
               {pcw_f1, ifw_f1, pen_f1, flush_f1, bub_f1, fa_f1, fb_f1}, cnt_f1, cnt_c4);
    end
    idle();
    mem_req = 1; mem_ready = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    idle();
    settle();
    checks++;
    if ({pcw_f1, ifw_f1, pen_f1, flush_f1, bub_f1, fa_f1, fb_f1} !== 9'b111_0_0_00_00 ||
        cnt_f1 !== 16'd0 || cnt_c4 !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_freeze: ctrl=%b cnt=%0d/%0d need 111000000 0/0",
               {pcw_f1, ifw_f1, pen_f1, flush_f1, bub_f1, fa_f1, fb_f1}, cnt_f1, cnt_c4);
    end
  endtask

  task automatic test_random();
    logic [8:0] got[3];
    longint     gcnt[3];
    logic [8:0] exp_v;
    bit         frz, hz;
    int         md;
    for (int md0 = 0; md0 < 2; md0++)
      for (int s = 0; s < 3; s++) mv[md0][s] = 0;
    for (int k = 0; k < 3; k++) mcnt[k] = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst         = ($urandom_range(0, 63) == 0);
      cnt_clr     = ($urandom_range(0, 39) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_rd       = 5'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom_range(0, 1));
      id_use_rt   = 1'($urandom_range(0, 1));
      id_regwrite = 1'($urandom_range(0, 1));
      id_memread  = 1'($urandom_range(0, 1));
      br_taken    = ($urandom_range(0, 2) == 0);
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ready   = 1'($urandom_range(0, 1));
      settle();
      got[0] = {pcw_f0, ifw_f0, flush_f0, bub_f0, pen_f0, fa_f0, fb_f0};
      got[1] = {pcw_f1, ifw_f1, flush_f1, bub_f1, pen_f1, fa_f1, fb_f1};
      got[2] = {pcw_c4, ifw_c4, flush_c4, bub_c4, pen_c4, fa_c4, fb_c4};
      gcnt[0] = longint'(cnt_f0);
      gcnt[1] = longint'(cnt_f1);
      gcnt[2] = longint'(cnt_c4);
      frz = mem_req && !mem_ready;
      for (int k = 0; k < 3; k++) begin
        md = (k == 0) ? 0 : 1;
        hz = m_hazard(md);
        exp_v = {!frz && !hz, !frz && !hz, br_taken && !hz && !frz, hz && !frz, !frz,
                 m_fwd(md, mrs[md][0]), m_fwd(md, mrt[md][0])};
        checks++;
        if (got[k] !== exp_v) begin
          errors++;
          $display("FAIL rand_ctrl inst%0d cyc%0d: got %b need %b", k, c, got[k], exp_v);
        end
        checks++;
        if (gcnt[k] != mcnt[k]) begin
          errors++;
          $display("FAIL rand_cnt inst%0d cyc%0d: got %0d need %0d", k, c, gcnt[k], mcnt[k]);
        end
      end
      model_tick();
      tick();
    end
    idle();
    rst = 0;
  endtask

  initial begin
    rst = 0;
    idle();
    test_reset();
    test_load_use();
    test_back_to_back();
    test_no_fwd();
    test_freeze();
    test_branch_hazard();
    test_counter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
